// File: rtl/imem_loader.sv
// imem_loader: boot-time framed byte-stream loader for the instruction memory.
// Holds the core in reset until the whole image is written and its checksum verified.
module imem_loader #(
  parameter int                     WORD_LENGTH = 32,
  parameter int                     DEPTH       = 256,
  parameter logic [WORD_LENGTH-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic [WORD_LENGTH-1:0] mem_write_add,
  output logic [WORD_LENGTH-1:0] mem_write_data,
  output logic                   mem_write_enable,
  output logic                   core_reset,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  csum;
  logic [7:0]  cnt_lo;
  logic [1:0]  byte_cnt;
  logic [15:0] word_idx;
  logic [15:0] word_last;
  logic [23:0] word_buf;
  logic [15:0] count;
  logic        listening;
  logic        take;
  logic        over;

  assign count     = {byte_data, cnt_lo};
  assign over      = {1'b0, count} > DEPTH_L;
  assign listening = (state == S_HDR0) || (state == S_HDR1) ||
                     (state == S_DATA) || (state == S_CSUM);
  assign byte_ready = listening && !reset;
  assign take       = byte_valid && byte_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR0;
    else       state <= state_nx;
  end

  // Frame sequencing and status outputs
  always_comb begin
    state_nx   = state;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_HDR0: begin
        if (take) state_nx = S_HDR1;
      end
      S_HDR1: begin
        if (take) begin
          unique case (1'b1)
            over:           state_nx = S_ERROR;
            (count == '0):  state_nx = S_CSUM;
            default:        state_nx = S_DATA;
          endcase
        end
      end
      S_DATA: begin
        if (take && byte_cnt == 2'd3 && word_idx == word_last)
          state_nx = S_CSUM;
      end
      S_CSUM: begin
        if (take)
          state_nx = (byte_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: state_nx = S_HDR0;
    endcase
  end

  // Header capture, running XOR, word assembly and write strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      csum             <= '0;
      cnt_lo           <= '0;
      byte_cnt         <= '0;
      word_idx         <= '0;
      word_last        <= '0;
      word_buf         <= '0;
      mem_write_enable <= 1'b0;
      mem_write_add    <= '0;
      mem_write_data   <= '0;
    end else begin
      mem_write_enable <= 1'b0;
      if (take) begin
        case (state)
          S_HDR0: begin
            cnt_lo <= byte_data;
            csum   <= csum ^ byte_data;
          end
          S_HDR1: begin
            word_last <= count - 16'd1;
            csum      <= csum ^ byte_data;
          end
          S_DATA: begin
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                mem_write_enable <= 1'b1;
                mem_write_add    <= BASE_ADDR +
                                    WORD_LENGTH'({word_idx, 2'b00});
                mem_write_data   <= WORD_LENGTH'({byte_data, word_buf});
                word_idx         <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random framed streams against a queue-based frame model.
// Checks strobe timing, written words, status timing and byte acceptance.
module tb_imem_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [31:0] mem_write_add;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        core_reset;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] got[$];

  imem_loader #(
    .WORD_LENGTH(32),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .mem_write_add(mem_write_add),
    .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable),
    .core_reset(core_reset),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_write_enable === 1'b1)
      got.push_back({mem_write_add, mem_write_data});

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    byte_valid = 1'b0;
    #1 check("rdy_in_rst", 32'(byte_ready), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_we", 32'(mem_write_enable), 0);
    check("rst_add", mem_write_add, 0);
    check("rst_data", mem_write_data, 0);
    check("rst_core", 32'(core_reset), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    #1 check("rst_rdy_after", 32'(byte_ready), 1);
  endtask

  task automatic send(input bq_t q, input int stall, input int stop_at);
    int n, ecap, lim, idx, cyc, refused, nw;
    bit exp_we, full, ovf, exp_done;
    logic rdy;
    logic [7:0] x;
    logic [31:0] w;
    n = int'({q[1], q[0]});
    ovf = n > DEPTH;
    full = stop_at < 0;
    lim = full ? q.size() : stop_at;
    ecap = ovf ? 2 : lim;
    idx = 0;
    cyc = 0;
    refused = 0;
    exp_we = 1'b0;
    w = '0;
    got.delete();
    while (idx < lim && refused < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      check("we", 32'(mem_write_enable), 32'(exp_we));
      check("ready", 32'(byte_ready), 32'(idx < ecap));
      check("err_busy", 32'(error), 32'(ovf && idx >= 2));
      check("core_busy", 32'(core_reset), 1);
      rdy = byte_ready;
      if ($urandom_range(99) < stall) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data = q[idx];
      end
      @(posedge clk);
      exp_we = 1'b0;
      if (byte_valid && rdy) begin
        exp_we = !ovf && idx >= 2 && idx < 2 + 4 * n &&
                 ((idx - 2) % 4 == 3);
        idx++;
      end else if (byte_valid) begin
        refused++;
      end
    end
    check("timeout", 32'(cyc < 2000), 1);
    @(negedge clk);
    byte_valid = 1'b0;
    check("we_last", 32'(mem_write_enable), 32'(exp_we));
    if (!full) return;
    x = 8'h00;
    for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
    exp_done = !ovf && (q[q.size()-1] == x);
    check("accepted", idx, ecap);
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(!exp_done));
    check("core_reset", 32'(core_reset), 32'(!exp_done));
    check("ready_end", 32'(byte_ready), 0);
    repeat (2) @(negedge clk);
    nw = ovf ? 0 : n;
    check("nwrites", got.size(), nw);
    for (int k = 0; k < nw && k < got.size(); k++) begin
      w = {q[2+4*k+3], q[2+4*k+2], q[2+4*k+1], q[2+4*k]};
      check("waddr", got[k][63:32], BASE + 32'(4 * k));
      check("wdata", got[k][31:0], w);
    end
    if (nw > 0) begin
      check("hold_add", mem_write_add, BASE + 32'(4 * (nw - 1)));
      check("hold_data", mem_write_data, w);
    end
    check("done_hold", 32'(done), 32'(exp_done));
  endtask

  initial begin
    bq_t q;
    int n;
    logic [7:0] x;

    do_reset();
    q = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send(q, 0, -1);

    do_reset();
    q = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
         8'h13, 8'h81, 8'h10, 8'h00, 8'h43};
    send(q, 40, -1);

    do_reset();
    q[q.size()-1] = 8'h44;
    send(q, 20, -1);

    do_reset();
    q = {8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    send(q, 0, -1);

    do_reset();
    q = {8'h00, 8'h00, 8'h00};
    send(q, 0, -1);

    do_reset();
    q = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send(q, 0, 4);
    do_reset();
    check("abort_nowrite", got.size(), 0);
    send(q, 0, -1);

    for (int it = 0; it < 40; it++) begin
      do_reset();
      n = $urandom_range(0, DEPTH + 1);
      q = {};
      q.push_back(8'(n));
      q.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      if ($urandom_range(3) == 0) x ^= 8'(1 << $urandom_range(7));
      q.push_back(x);
      send(q, $urandom_range(0, 50), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
